// File: rtl/sdram_init_checker.sv
// Passive monitor for the SDRAM power-up initialization sequence.
// Watches the command bus and flags the first ordering or timing violation
// with a sticky code. It also captures the mode register programmed by LOAD MODE.
module sdram_init_checker #(
    parameter int unsigned T_POWERUP = 20000,
    parameter int unsigned T_RP      = 2,
    parameter int unsigned T_RFC     = 7,
    parameter int unsigned T_MRD     = 2,
    parameter int unsigned N_AREF    = 2
) (
    input  logic        sysclk_100M,
    input  logic        rst,
    input  logic [3:0]  cmd_reg,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_addr,
    input  logic        init_end_flag,
    output logic        init_ok,
    output logic        init_err,
    output logic [3:0]  err_code,
    output logic [3:0]  aref_cnt,
    output logic [12:0] mode_reg,
    output logic [1:0]  mode_ba
);

    typedef enum logic [2:0] {
        StPowerup,
        StWaitPre,
        StWaitAref,
        StArefLoop,
        StTmrd,
        StDone,
        StError
    } state_e;

    // Type of the most recent command, used only for the gap checks.
    typedef enum logic [1:0] {
        LastNone,
        LastPre,
        LastAref,
        LastOther
    } last_e;

    localparam logic [3:0] ErrEarly     = 4'd1;
    localparam logic [3:0] ErrPreBank   = 4'd2;
    localparam logic [3:0] ErrOrder     = 4'd3;
    localparam logic [3:0] ErrFewAref   = 4'd4;
    localparam logic [3:0] ErrTrp       = 4'd5;
    localparam logic [3:0] ErrTrfc      = 4'd6;
    localparam logic [3:0] ErrTmrd      = 4'd7;
    localparam logic [3:0] ErrFlagEarly = 4'd8;

    // POWERUP is left on the edge that makes pu_cnt reach T_POWERUP, so the
    // first sample seen with pu_cnt == T_POWERUP is already in WAIT_PRE.
    localparam logic [15:0] PuLast = 16'(T_POWERUP - 1);
    localparam logic [7:0]  TRp    = 8'(T_RP);
    localparam logic [7:0]  TRfc   = 8'(T_RFC);
    localparam logic [7:0]  TMrd   = 8'(T_MRD);
    localparam logic [3:0]  NAref  = 4'(N_AREF);

    state_e      state_q, state_d;
    last_e       last_q, last_d;
    logic [15:0] pu_cnt_q, pu_cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic [3:0]  err_code_q, err_code_d;
    logic [3:0]  aref_cnt_q, aref_cnt_d;
    logic [12:0] mode_reg_q, mode_reg_d;
    logic [1:0]  mode_ba_q, mode_ba_d;

    logic       is_cmd, is_pre, is_aref, is_lmr;
    logic       timing_err;
    logic [3:0] timing_code;
    logic       fault;
    logic [3:0] fault_code;

    // Command decode; CS_n high is DESELECT and behaves as NOP.
    always_comb begin
        is_cmd  = (cmd_reg[3] == 1'b0) && (cmd_reg != 4'b0111);
        is_pre  = (cmd_reg == 4'b0010);
        is_aref = (cmd_reg == 4'b0001);
        is_lmr  = (cmd_reg == 4'b0000);
    end

    // Free-running counters and previous-command tracking.
    always_comb begin
        pu_cnt_d = (pu_cnt_q == 16'hFFFF) ? pu_cnt_q : pu_cnt_q + 16'd1;
        gap_d    = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
        last_d   = last_q;
        if (is_cmd) begin
            gap_d = 8'd1;
            if (is_pre) begin
                last_d = LastPre;
            end else if (is_aref) begin
                last_d = LastAref;
            end else begin
                last_d = LastOther;
            end
        end
    end

    // Minimum spacing after PRECHARGE / AUTO REFRESH.
    always_comb begin
        timing_err  = 1'b0;
        timing_code = 4'd0;
        if (is_cmd && (last_q == LastPre) && (gap_q < TRp)) begin
            timing_err  = 1'b1;
            timing_code = ErrTrp;
        end else if (is_cmd && (last_q == LastAref) && (gap_q < TRfc)) begin
            timing_err  = 1'b1;
            timing_code = ErrTrfc;
        end
    end

    // Sequence FSM next state; the first fault wins and ERROR is absorbing.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        aref_cnt_d = aref_cnt_q;
        mode_reg_d = mode_reg_q;
        mode_ba_d  = mode_ba_q;
        fault      = 1'b0;
        fault_code = 4'd0;

        unique case (state_q)
            StPowerup: begin
                if (is_cmd) begin
                    fault      = 1'b1;
                    fault_code = ErrEarly;
                end else if (pu_cnt_q >= PuLast) begin
                    state_d = StWaitPre;
                end
            end
            StWaitPre: begin
                if (timing_err) begin
                    fault      = 1'b1;
                    fault_code = timing_code;
                end else if (is_pre && sdram_addr[10]) begin
                    state_d = StWaitAref;
                end else if (is_pre) begin
                    fault      = 1'b1;
                    fault_code = ErrPreBank;
                end else if (is_cmd) begin
                    fault      = 1'b1;
                    fault_code = ErrOrder;
                end
            end
            StWaitAref, StArefLoop: begin
                if (timing_err) begin
                    fault      = 1'b1;
                    fault_code = timing_code;
                end else if (is_aref) begin
                    aref_cnt_d = (aref_cnt_q == 4'hF) ? aref_cnt_q : aref_cnt_q + 4'd1;
                    state_d    = StArefLoop;
                end else if (is_lmr && (aref_cnt_q >= NAref)) begin
                    mode_reg_d = sdram_addr;
                    mode_ba_d  = sdram_ba;
                    state_d    = StTmrd;
                end else if (is_lmr) begin
                    fault      = 1'b1;
                    fault_code = ErrFewAref;
                end else if (is_cmd) begin
                    fault      = 1'b1;
                    fault_code = ErrOrder;
                end
            end
            StTmrd: begin
                if (is_cmd && (gap_q < TMrd)) begin
                    fault      = 1'b1;
                    fault_code = ErrTmrd;
                end else if (gap_q == TMrd) begin
                    state_d = StDone;
                end
            end
            StDone: begin
            end
            StError: begin
            end
            default: begin
                state_d = StPowerup;
            end
        endcase

        // The controller must not claim completion before the sequence does.
        if (!fault && init_end_flag && (state_q != StDone) && (state_q != StError)) begin
            fault      = 1'b1;
            fault_code = ErrFlagEarly;
        end

        if (fault) begin
            state_d    = StError;
            err_code_d = fault_code;
        end
    end

    // State and capture registers with synchronous reset.
    always_ff @(posedge sysclk_100M) begin
        if (rst) begin
            state_q    <= StPowerup;
            last_q     <= LastNone;
            pu_cnt_q   <= 16'd0;
            gap_q      <= 8'd0;
            err_code_q <= 4'd0;
            aref_cnt_q <= 4'd0;
            mode_reg_q <= 13'd0;
            mode_ba_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            pu_cnt_q   <= pu_cnt_d;
            gap_q      <= gap_d;
            err_code_q <= err_code_d;
            aref_cnt_q <= aref_cnt_d;
            mode_reg_q <= mode_reg_d;
            mode_ba_q  <= mode_ba_d;
        end
    end

    // Outputs are straight decodes of registered state.
    always_comb begin
        init_ok  = (state_q == StDone);
        init_err = (state_q == StError);
        err_code = err_code_q;
        aref_cnt = aref_cnt_q;
        mode_reg = mode_reg_q;
        mode_ba  = mode_ba_q;
    end

endmodule

// File: tb/tb_sdram_init_checker.sv
// Directed bench for sdram_init_checker; power-up wait shortened to keep runs short.
module tb_sdram_init_checker;

    localparam int unsigned TPU = 64;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_DES  = 4'b1000;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_LMR  = 4'b0000;
    localparam logic [3:0] C_ACT  = 4'b0011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  cmd_reg = 4'b0111;
    logic [1:0]  sdram_ba = 2'd0;
    logic [12:0] sdram_addr = 13'd0;
    logic        init_end_flag = 1'b0;
    logic        init_ok, init_err;
    logic [3:0]  err_code, aref_cnt;
    logic [12:0] mode_reg;
    logic [1:0]  mode_ba;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sdram_init_checker #(.T_POWERUP(TPU)) dut (
        .sysclk_100M   (clk),
        .rst           (rst),
        .cmd_reg       (cmd_reg),
        .sdram_ba      (sdram_ba),
        .sdram_addr    (sdram_addr),
        .init_end_flag (init_end_flag),
        .init_ok       (init_ok),
        .init_err      (init_err),
        .err_code      (err_code),
        .aref_cnt      (aref_cnt),
        .mode_reg      (mode_reg),
        .mode_ba       (mode_ba)
    );

    // One bus sample: apply inputs, then return just after the capturing edge.
    task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr,
                         input logic flag);
        cmd_reg       = c;
        sdram_ba      = ba;
        sdram_addr    = addr;
        init_end_flag = flag;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) drive(C_NOP, 2'd0, 13'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(C_NOP, 2'd0, 13'd0, 1'b0);
        rst = 1'b0;
    endtask

    // PRE(A10=1), 1 NOP, then n x {AREF, 6 NOP}.
    task automatic to_aref_loop(input int n);
        drive(C_PRE, 2'd0, 13'h0400, 1'b0);
        nops(1);
        for (int i = 0; i < n; i++) begin
            drive(C_AREF, 2'd0, 13'd0, 1'b0);
            nops(6);
        end
    endtask

    task automatic run_to_done(input logic [1:0] ba, input logic [12:0] addr);
        do_reset();
        nops(TPU);
        to_aref_loop(2);
        drive(C_LMR, ba, addr, 1'b0);
        nops(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(C_LMR, 2'd3, 13'h1FFF, 1'b1);
        rst = 1'b0;
        checks++; if (init_ok !== 1'b0) begin errors++; $display("FAIL reset_init_ok: got %b want 0", init_ok); end
        checks++; if (init_err !== 1'b0) begin errors++; $display("FAIL reset_init_err: got %b want 0", init_err); end
        checks++; if (err_code !== 4'd0) begin errors++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
        checks++; if (aref_cnt !== 4'd0) begin errors++; $display("FAIL reset_aref_cnt: got %0d want 0", aref_cnt); end
        checks++; if (mode_reg !== 13'd0) begin errors++; $display("FAIL reset_mode_reg: got %h want 0", mode_reg); end
        checks++; if (mode_ba !== 2'd0) begin errors++; $display("FAIL reset_mode_ba: got %0d want 0", mode_ba); end
        drive(C_DES, 2'd0, 13'd0, 1'b0);
        checks++; if (init_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_ignored: got init_err=%b want 0", init_err); end
    endtask

    task automatic test_legal();
        do_reset();
        nops(TPU);
        to_aref_loop(2);
        checks++; if (aref_cnt !== 4'd2) begin errors++; $display("FAIL legal_aref_cnt: got %0d want 2", aref_cnt); end
        checks++; if (init_err !== 1'b0) begin errors++; $display("FAIL legal_no_err_gap7: got %b want 0", init_err); end
        drive(C_LMR, 2'd0, 13'h032, 1'b0);
        checks++; if (mode_reg !== 13'h032) begin errors++; $display("FAIL legal_mode_reg: got %h want 032", mode_reg); end
        checks++; if (mode_ba !== 2'd0) begin errors++; $display("FAIL legal_mode_ba: got %0d want 0", mode_ba); end
        checks++; if (init_ok !== 1'b0) begin errors++; $display("FAIL legal_ok_edge1: got %b want 0", init_ok); end
        nops(1);
        checks++; if (init_ok !== 1'b0) begin errors++; $display("FAIL legal_ok_edge2: got %b want 0", init_ok); end
        nops(1);
        checks++; if (init_ok !== 1'b1) begin errors++; $display("FAIL legal_ok_edge3: got %b want 1", init_ok); end
        checks++; if (init_err !== 1'b0 || err_code !== 4'd0) begin
            errors++; $display("FAIL legal_final_err: got err=%b code=%0d want 0/0", init_err, err_code);
        end
    endtask

    task automatic test_early();
        do_reset();
        nops(TPU - 1);
        drive(C_PRE, 2'd0, 13'h0400, 1'b0);
        checks++; if (init_err !== 1'b1 || err_code !== 4'd1) begin
            errors++; $display("FAIL early_code: got err=%b code=%0d want 1/1", init_err, err_code);
        end
        nops(4);
        to_aref_loop(2);
        drive(C_LMR, 2'd0, 13'h032, 1'b0);
        nops(3);
        checks++; if (init_ok !== 1'b0 || err_code !== 4'd1) begin
            errors++; $display("FAIL early_no_recover: got ok=%b code=%0d want 0/1", init_ok, err_code);
        end
    endtask

    task automatic test_trp();
        do_reset();
        nops(TPU);
        drive(C_PRE, 2'd0, 13'h0400, 1'b0);
        drive(C_AREF, 2'd0, 13'd0, 1'b0);
        checks++; if (err_code !== 4'd5) begin errors++; $display("FAIL trp_code: got %0d want 5", err_code); end
        drive(C_NOP, 2'd0, 13'd0, 1'b1);
        drive(C_PRE, 2'd0, 13'd0, 1'b0);
        checks++; if (err_code !== 4'd5 || init_err !== 1'b1) begin
            errors++; $display("FAIL trp_sticky: got err=%b code=%0d want 1/5", init_err, err_code);
        end
    endtask

    task automatic test_trfc();
        do_reset();
        nops(TPU);
        drive(C_PRE, 2'd0, 13'h0400, 1'b0);
        nops(1);
        drive(C_AREF, 2'd0, 13'd0, 1'b0);
        nops(5);
        drive(C_AREF, 2'd0, 13'd0, 1'b0);
        checks++; if (err_code !== 4'd6) begin errors++; $display("FAIL trfc_code: got %0d want 6", err_code); end
    endtask

    task automatic test_pre_bank();
        do_reset();
        nops(TPU);
        drive(C_PRE, 2'd1, 13'h1BFF, 1'b0);
        checks++; if (err_code !== 4'd2) begin errors++; $display("FAIL pre_bank_code: got %0d want 2", err_code); end
    endtask

    task automatic test_few_aref();
        do_reset();
        nops(TPU);
        to_aref_loop(1);
        drive(C_LMR, 2'd0, 13'h032, 1'b0);
        checks++; if (err_code !== 4'd4) begin errors++; $display("FAIL few_aref_code: got %0d want 4", err_code); end
        checks++; if (mode_reg !== 13'd0) begin errors++; $display("FAIL few_aref_no_capture: got %h want 0", mode_reg); end
    endtask

    task automatic test_active();
        do_reset();
        nops(TPU);
        drive(C_ACT, 2'd0, 13'h0400, 1'b0);
        checks++; if (err_code !== 4'd3) begin errors++; $display("FAIL active_code: got %0d want 3", err_code); end
    endtask

    task automatic test_flag();
        do_reset();
        nops(TPU);
        drive(C_PRE, 2'd0, 13'h0400, 1'b0);
        nops(1);
        drive(C_AREF, 2'd0, 13'd0, 1'b0);
        nops(1);
        checks++; if (init_err !== 1'b0) begin errors++; $display("FAIL flag_pre_state: got err=%b want 0", init_err); end
        drive(C_NOP, 2'd0, 13'd0, 1'b1);
        checks++; if (init_err !== 1'b1 || err_code !== 4'd8) begin
            errors++; $display("FAIL flag_code: got err=%b code=%0d want 1/8", init_err, err_code);
        end
    endtask

    task automatic test_tmrd();
        do_reset();
        nops(TPU);
        to_aref_loop(2);
        drive(C_LMR, 2'd0, 13'h032, 1'b0);
        drive(C_AREF, 2'd0, 13'd0, 1'b0);
        checks++; if (err_code !== 4'd7) begin errors++; $display("FAIL tmrd_code: got %0d want 7", err_code); end
        nops(3);
        checks++; if (init_ok !== 1'b0) begin errors++; $display("FAIL tmrd_no_ok: got %b want 0", init_ok); end
    endtask

    task automatic test_done();
        run_to_done(2'd2, 13'h1A5);
        checks++; if (init_ok !== 1'b1 || mode_reg !== 13'h1A5 || mode_ba !== 2'd2) begin
            errors++; $display("FAIL done_capture: got ok=%b reg=%h ba=%0d want 1/1a5/2", init_ok, mode_reg, mode_ba);
        end
        drive(C_PRE, 2'd0, 13'd0, 1'b0);
        drive(C_AREF, 2'd0, 13'd0, 1'b0);
        drive(C_ACT, 2'd1, 13'h0123, 1'b0);
        drive(C_LMR, 2'd3, 13'h0007, 1'b1);
        checks++; if (init_ok !== 1'b1 || init_err !== 1'b0) begin
            errors++; $display("FAIL done_garbage: got ok=%b err=%b want 1/0", init_ok, init_err);
        end
        checks++; if (mode_reg !== 13'h1A5) begin errors++; $display("FAIL done_mode_held: got %h want 1a5", mode_reg); end
        do_reset();
        checks++; if (init_ok !== 1'b0 || mode_reg !== 13'd0 || mode_ba !== 2'd0 || aref_cnt !== 4'd0) begin
            errors++; $display("FAIL done_reset: got ok=%b reg=%h ba=%0d aref=%0d want 0", init_ok, mode_reg, mode_ba, aref_cnt);
        end
        drive(C_PRE, 2'd0, 13'h0400, 1'b0);
        checks++; if (err_code !== 4'd1) begin errors++; $display("FAIL done_reset_pu_again: got %0d want 1", err_code); end
        run_to_done(2'd0, 13'h032);
        checks++; if (init_ok !== 1'b1 || init_err !== 1'b0) begin
            errors++; $display("FAIL done_rerun: got ok=%b err=%b want 1/0", init_ok, init_err);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_legal();
        test_early();
        test_trp();
        test_trfc();
        test_pre_bank();
        test_few_aref();
        test_active();
        test_flag();
        test_tmrd();
        test_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
